wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Final pipeline stage; sits directly downstream of the memory-access stage and consumes its 136-bit stage bus.
- Registers the incoming bus and drives the GPR write port, which is fed back as `wb_to_rf_bus`.
- Owns the architectural HI/LO registers and drives the debug write-back trace.
- Keeps a retired-instruction counter.

Parameters:
- MEM_TO_WB_WD, 136, width of incoming stage bus.
- WB_TO_RF_WD, 38, width of GPR write bus ({we, waddr[4:0], wdata[31:0]}).
- STALL_W, 6, width of the stall vector.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- flush  in  1  clear stage register
- stall  in  STALL_W  pipeline stall vector; bit 4 = WB, bit 5 = downstream; 1 = Stop
- mem_to_wb_bus  in  MEM_TO_WB_WD  fields:
  - [135] hi_we, [134] lo_we
  - [133:102] hi_wdata, [101:70] lo_wdata
  - [69:38] pc
  - [37] rf_we, [36:32] rf_waddr, [31:0] rf_wdata
- wb_to_rf_bus  out  WB_TO_RF_WD  {rf_we, rf_waddr, rf_wdata} from stage register
- hi_rdata  out  32  current HI value for the EX stage (mfhi)
- lo_rdata  out  32  current LO value for the EX stage (mflo)
- retire_cnt  out  32  retired-instruction count
- debug_wb_pc  out  32  pc of the entry in WB
- debug_wb_rf_wen  out  4  {4{rf_we}}
- debug_wb_rf_wnum  out  5  rf_waddr
- debug_wb_rf_wdata  out  32  rf_wdata

Behaviour:
- Reset (rst=0, asynchronous):
  - Stage register, hi_r, lo_r and retire_cnt all clear to 0.
  - Every output therefore reads 0 immediately, without waiting for a clock edge.
- Stage register update on each clk edge, in priority order:
  - flush=1 → load 0.
  - stall[4]=1 and stall[5]=0 → load 0 (bubble).
  - stall[4]=0 → load mem_to_wb_bus.
  - Otherwise → hold.
- Latency: one cycle from mem_to_wb_bus to all GPR and debug outputs.
- A bubble is an all-zero entry: rf_we=0, hi_we=0, lo_we=0, pc=0.
- HI/LO commit: on each clk edge, if the stage-register hi_we=1, hi_r <= hi_wdata; likewise for LO.
  - Commit uses the current register contents and is independent of flush/stall on that edge; the entry already in WB is architecturally committed.
  - A held (stalled) entry rewrites the same value each cycle, which is idempotent.
  - hi_we and lo_we both set commits both registers on the same edge.
- HI/LO read path: hi_rdata/lo_rdata follow the optional-feature rules below.
- Retire counter:
  - Increments by 1 on an edge where the stage register loads a new entry (stall[4]=0, flush=0) and the incoming pc != 0.
  - Bubbles and flushed entries do not count.
  - Wraps 0xFFFFFFFF → 0.
- GPR write: wb_to_rf_bus passes rf_we through unchanged, including for rf_waddr=0; the register file ignores writes to r0.
- Reset mid-operation: a pending HI/LO write in the stage register is lost; HI/LO stay 0.

Optional Feature:
- Macro: WB_HILO_BYPASS_EN.
- Defined:
  - hi_rdata = stage-register hi_we ? hi_wdata : hi_r.
  - lo_rdata uses the same rule with lo_we / lo_wdata / lo_r.
  - An mfhi/mflo in EX sees the value pending in WB with no stall.
- Undefined:
  - hi_rdata = hi_r and lo_rdata = lo_r.
  - The pending write becomes visible one cycle later; the hazard unit must stall.

Test Plan:
1. Reset release, then mem_to_wb_bus with pc=0xBFC00000, rf_we=1, waddr=8, wdata=0x1234 → next cycle wb_to_rf_bus={1,8,0x1234}, debug_wb_rf_wen=0xF, debug_wb_pc=0xBFC00000, retire_cnt=1.
2. Entry with hi_we=1, hi_wdata=0xDEADBEEF, lo_we=1, lo_wdata=0x5 →
   - With bypass: hi_rdata=0xDEADBEEF in the cycle the entry is in WB.
   - Without bypass: 0 that cycle, 0xDEADBEEF the next.
   - lo_rdata=0x5 thereafter in both builds.
3. stall=6'b010000 for 3 cycles with a valid entry in WB → stage register loads a bubble (all outputs 0) each cycle; retire_cnt unchanged.
4. stall=6'b110000 → entry held, outputs stable, retire_cnt not re-incremented; flush=1 on the next edge → outputs 0, retire_cnt unchanged.
5. Force retire_cnt to 0xFFFFFFFF, then retire one valid instruction → retire_cnt=0.
6. Assert rst=0 mid-cycle while hi_we=1 is pending → hi_rdata, retire_cnt and all debug outputs go to 0 before the next clk edge; hi_r stays 0 after release.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: write-back stage register, GPR write port, HI/LO registers, debug trace, retire counter.
// Define WB_HILO_BYPASS_EN to forward a pending HI/LO write straight to hi_rdata/lo_rdata.
module wb_stage #(
   parameter int MEM_TO_WB_WD = 136,
   parameter int WB_TO_RF_WD  = 38,
   parameter int STALL_W      = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic [STALL_W-1:0]      stall,
   input  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [WB_TO_RF_WD-1:0]  wb_to_rf_bus,
   output logic [31:0]             hi_rdata,
   output logic [31:0]             lo_rdata,
   output logic [31:0]             retire_cnt,
   output logic [31:0]             debug_wb_pc,
   output logic [3:0]              debug_wb_rf_wen,
   output logic [4:0]              debug_wb_rf_wnum,
   output logic [31:0]             debug_wb_rf_wdata
);
   logic [MEM_TO_WB_WD-1:0] stage_q, stage_d;
   logic [31:0]             hi_q, hi_d, lo_q, lo_d, retire_cnt_q, retire_cnt_d;
   logic                    retire;

   always_comb begin
      stage_d      = flush                  ? '0 :
                     (stall[4] && !stall[5]) ? '0 :
                     !stall[4]               ? mem_to_wb_bus : stage_q;
      // the entry already in WB commits regardless of what happens to the stage register
      hi_d         = stage_q[135] ? stage_q[133:102] : hi_q;
      lo_d         = stage_q[134] ? stage_q[101:70]  : lo_q;
      retire       = !flush && !stall[4] && (mem_to_wb_bus[69:38] != 32'd0);
      retire_cnt_d = retire_cnt_q + {31'd0, retire};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_q      <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         retire_cnt_q <= '0;
      end else begin
         stage_q      <= stage_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign wb_to_rf_bus      = stage_q[37:0];
   assign retire_cnt        = retire_cnt_q;
   assign debug_wb_pc       = stage_q[69:38];
   assign debug_wb_rf_wen   = {4{stage_q[37]}};
   assign debug_wb_rf_wnum  = stage_q[36:32];
   assign debug_wb_rf_wdata = stage_q[31:0];

`ifdef WB_HILO_BYPASS_EN
   assign hi_rdata = stage_q[135] ? stage_q[133:102] : hi_q;
   assign lo_rdata = stage_q[134] ? stage_q[101:70]  : lo_q;
`else
   assign hi_rdata = hi_q;
   assign lo_rdata = lo_q;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: vector table, hand sequences and randomized run of wb_stage against a field-level model.
module tb_wb_stage;
   typedef struct packed {
      logic        hi_we;
      logic        lo_we;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] pc;
      logic        rf_we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } entry_t;

   typedef struct {
      entry_t      e;
      logic [5:0]  s;
      logic        f;
      logic [37:0] x_rf;
      logic [31:0] x_pc;
      logic [31:0] x_cnt;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         flush = 1'b0;
   logic [5:0]   stall = '0;
   logic [135:0] mem_to_wb_bus = '0;
   logic [37:0]  wb_to_rf_bus;
   logic [31:0]  hi_rdata, lo_rdata, retire_cnt, debug_wb_pc, debug_wb_rf_wdata;
   logic [3:0]   debug_wb_rf_wen;
   logic [4:0]   debug_wb_rf_wnum;

   int     n_chk = 0;
   int     n_fail = 0;
   entry_t m_ent = '0;
   logic [31:0] m_hi = '0, m_lo = '0, m_cnt = '0;
   vec_t   tbl[10];

   wb_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall), .mem_to_wb_bus(mem_to_wb_bus),
      .wb_to_rf_bus(wb_to_rf_bus), .hi_rdata(hi_rdata), .lo_rdata(lo_rdata),
      .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   always #5 clk = ~clk;

   function automatic entry_t mk(logic [31:0] pc, logic we, logic [4:0] a, logic [31:0] d);
      entry_t e = '0;
      e.pc = pc; e.rf_we = we; e.waddr = a; e.wdata = d;
      return e;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_all(string tag);
      logic [31:0] xh, xl;
`ifdef WB_HILO_BYPASS_EN
      xh = m_ent.hi_we ? m_ent.hi : m_hi;
      xl = m_ent.lo_we ? m_ent.lo : m_lo;
`else
      xh = m_hi;
      xl = m_lo;
`endif
      chk({tag, ".rf_bus"}, 64'(wb_to_rf_bus), 64'({m_ent.rf_we, m_ent.waddr, m_ent.wdata}));
      chk({tag, ".hi"}, 64'(hi_rdata), 64'(xh));
      chk({tag, ".lo"}, 64'(lo_rdata), 64'(xl));
      chk({tag, ".cnt"}, 64'(retire_cnt), 64'(m_cnt));
      chk({tag, ".pc"}, 64'(debug_wb_pc), 64'(m_ent.pc));
      chk({tag, ".wen"}, 64'(debug_wb_rf_wen), 64'(m_ent.rf_we ? 4'hF : 4'h0));
      chk({tag, ".wnum"}, 64'(debug_wb_rf_wnum), 64'(m_ent.waddr));
      chk({tag, ".wdata"}, 64'(debug_wb_rf_wdata), 64'(m_ent.wdata));
   endtask

   // one clock: drive inputs, advance the model on the edge, then sample 1 time unit later
   task automatic step(entry_t e, logic [5:0] s, logic f);
      mem_to_wb_bus = e;
      stall = s;
      flush = f;
      @(posedge clk);
      if (m_ent.hi_we) m_hi = m_ent.hi;
      if (m_ent.lo_we) m_lo = m_ent.lo;
      if (!f && !s[4] && e.pc != 0) m_cnt = m_cnt + 1;
      if (f || (s[4] && !s[5])) m_ent = '0;
      else if (!s[4]) m_ent = e;
      #1;
   endtask

   initial begin
      entry_t e;
      tbl[0] = '{mk(32'hBFC00000, 1, 8, 32'h1234), 6'b000000, 0, {1'b1, 5'd8, 32'h1234}, 32'hBFC00000, 1};
      tbl[1] = '{mk(32'hBFC00004, 1, 9, 32'hAAAA), 6'b010000, 0, 38'd0, 32'd0, 1};
      tbl[2] = '{mk(32'hBFC00004, 1, 9, 32'hAAAA), 6'b010000, 0, 38'd0, 32'd0, 1};
      tbl[3] = '{mk(32'hBFC00004, 1, 9, 32'hAAAA), 6'b010000, 0, 38'd0, 32'd0, 1};
      tbl[4] = '{mk(32'hBFC00008, 1, 3, 32'h77), 6'b000000, 0, {1'b1, 5'd3, 32'h77}, 32'hBFC00008, 2};
      tbl[5] = '{mk(32'hBFC0000C, 1, 6, 32'h66), 6'b110000, 0, {1'b1, 5'd3, 32'h77}, 32'hBFC00008, 2};
      tbl[6] = '{mk(32'hBFC0000C, 1, 6, 32'h66), 6'b110000, 0, {1'b1, 5'd3, 32'h77}, 32'hBFC00008, 2};
      tbl[7] = '{mk(32'hBFC0000C, 1, 6, 32'h66), 6'b000000, 1, 38'd0, 32'd0, 2};
      tbl[8] = '{mk(32'h0, 1, 0, 32'h5), 6'b000000, 0, {1'b1, 5'd0, 32'h5}, 32'd0, 2};
      tbl[9] = '{mk(32'hBFC00010, 0, 4, 32'h99), 6'b000000, 0, {1'b0, 5'd4, 32'h99}, 32'hBFC00010, 3};

      #3;
      check_all("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].e, tbl[i].s, tbl[i].f);
         chk($sformatf("vec%0d.rf_bus", i), 64'(wb_to_rf_bus), 64'(tbl[i].x_rf));
         chk($sformatf("vec%0d.pc", i), 64'(debug_wb_pc), 64'(tbl[i].x_pc));
         chk($sformatf("vec%0d.wen", i), 64'(debug_wb_rf_wen), 64'(tbl[i].x_rf[37] ? 4'hF : 4'h0));
         chk($sformatf("vec%0d.cnt", i), 64'(retire_cnt), 64'(tbl[i].x_cnt));
         check_all($sformatf("vec%0d", i));
      end

      e = mk(32'hBFC00020, 0, 0, 0);
      e.hi_we = 1; e.hi = 32'hDEADBEEF; e.lo_we = 1; e.lo = 32'h5;
      step(e, 0, 0);
`ifdef WB_HILO_BYPASS_EN
      chk("hilo.hi_inwb", 64'(hi_rdata), 64'(32'hDEADBEEF));
`else
      chk("hilo.hi_inwb", 64'(hi_rdata), 64'(32'h0));
`endif
      check_all("hilo0");
      step(mk(32'hBFC00024, 0, 0, 0), 0, 0);
      chk("hilo.hi_next", 64'(hi_rdata), 64'(32'hDEADBEEF));
      chk("hilo.lo_next", 64'(lo_rdata), 64'(32'h5));
      check_all("hilo1");

      force dut.retire_cnt_q = 32'hFFFFFFFF;
      #1;
      release dut.retire_cnt_q;
      m_cnt = 32'hFFFFFFFF;
      chk("wrap.pre", 64'(retire_cnt), 64'(32'hFFFFFFFF));
      step(mk(32'hBFC00028, 1, 2, 32'h2), 0, 0);
      chk("wrap.post", 64'(retire_cnt), 64'(32'h0));
      check_all("wrap");

      e = mk(32'hBFC0002C, 1, 7, 32'h7);
      e.hi_we = 1; e.hi = 32'hCAFEF00D;
      step(e, 0, 0);
      rst = 1'b0;
      #1;
      m_ent = '0; m_hi = '0; m_lo = '0; m_cnt = '0;
      chk("rst.hi", 64'(hi_rdata), 64'(32'h0));
      chk("rst.cnt", 64'(retire_cnt), 64'(32'h0));
      chk("rst.pc", 64'(debug_wb_pc), 64'(32'h0));
      check_all("rst_async");
      mem_to_wb_bus = '0;
      @(negedge clk);
      rst = 1'b1;
      step(mk(32'h0, 0, 0, 0), 0, 0);
      step(mk(32'h0, 0, 0, 0), 0, 0);
      chk("rst.hi_after", 64'(hi_rdata), 64'(32'h0));
      check_all("rst_after");

      for (int i = 0; i < 400; i++) begin
         e = entry_t'({$urandom, $urandom, $urandom, $urandom, $urandom, 8'($urandom)});
         if ($urandom_range(7) == 0) e.pc = 0;
         e.hi_we = ($urandom_range(3) == 0);
         e.lo_we = ($urandom_range(3) == 0);
         step(e, {1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0), 4'($urandom)},
              1'($urandom_range(9) == 0));
         check_all($sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
